text_console: RTL and testbench

//  Character-stream front end for the VGA terminal text RAM. Accepts one ASCII

---
 rtl/text_console_if.sv | 25 ++
 rtl/text_console.sv | 169 ++++++++++++++++
 tb/tb_text_console.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_if.sv
// Character handshake, text RAM port and cursor bundle between a byte source
// and the text_console front end.
interface text_console_if #(
  parameter int ADDR_W = 12
);
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic [ADDR_W-1:0] text_addr;
  logic              text_write;
  logic [7:0]        text_in;
  logic [7:0]        text_out;
  logic [6:0]        cursor_col;
  logic [4:0]        cursor_row;

  modport master (
    output char_valid, char_data, text_out,
    input  char_ready, text_addr, text_write, text_in, cursor_col, cursor_row
  );

  modport slave (
    input  char_valid, char_data, text_out,
    output char_ready, text_addr, text_write, text_in, cursor_col, cursor_row
  );
endinterface

// File: rtl/text_console.sv
// Cursor-tracking character front end for the terminal text RAM: prints bytes,
// handles CR/LF/BS/FF, wraps lines and scrolls the screen up one row in hardware.
module text_console #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  text_console_if.slave  bus
);
  localparam int N  = COLS * ROWS;
  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, WRITE, SCR_RD, SCR_CAP, SCR_WR, SCR_CLR, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        din_q, din_d;
  logic              rdy_q, rdy_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              scroll_q, scroll_d;

  logic [7:0]        ch;
  logic              printable;
  logic [ADDR_W-1:0] cur_addr;

  assign ch        = bus.char_data;
  assign printable = (ch >= 8'h20) && (ch <= 8'h7E);
  assign cur_addr  = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      din_q    <= '0;
      rdy_q    <= 1'b0;
      cnt_q    <= '0;
      scroll_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      din_q    <= din_d;
      rdy_q    <= rdy_d;
      cnt_q    <= cnt_d;
      scroll_q <= scroll_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    din_d    = din_q;
    rdy_d    = 1'b0;
    cnt_d    = cnt_q;
    scroll_d = scroll_q;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (bus.char_valid && rdy_q) begin
          rdy_d    = 1'b0;
          state_d  = WRITE;
          scroll_d = 1'b0;
          if (printable) begin
            we_d   = 1'b1;
            addr_d = cur_addr;
            din_d  = ch;
            if (col_q == 7'(COLS - 1)) begin
              col_d = '0;
              if (row_q == 5'(ROWS - 1)) scroll_d = 1'b1;
              else                       row_d    = row_q + 5'd1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else if (ch == 8'h0A) begin
            col_d = '0;
            // LF on the last row starts the scroll straight from the accept edge
            if (row_q == 5'(ROWS - 1)) begin
              state_d = SCR_RD;
              addr_d  = ADDR_W'(COLS);
              cnt_d   = CW'(COLS);
            end else begin
              row_d = row_q + 5'd1;
            end
          end else if (ch == 8'h0D) begin
            col_d = '0;
          end else if (ch == 8'h08) begin
            if (col_q != '0) begin
              col_d  = col_q - 7'd1;
              we_d   = 1'b1;
              addr_d = cur_addr - ADDR_W'(1);
              din_d  = 8'h20;
            end
          end else if (ch == 8'h0C) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end
        end
      end
      WRITE: begin
        if (scroll_q) begin
          scroll_d = 1'b0;
          state_d  = SCR_RD;
          addr_d   = ADDR_W'(COLS);
          cnt_d    = CW'(COLS);
        end else begin
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      SCR_RD: state_d = SCR_CAP;
      SCR_CAP: begin
        // text_out now holds the cell addressed during SCR_RD
        din_d   = bus.text_out;
        addr_d  = addr_q - ADDR_W'(COLS);
        we_d    = 1'b1;
        state_d = SCR_WR;
      end
      SCR_WR: begin
        if (cnt_q == CW'(N - 1)) begin
          we_d    = 1'b1;
          addr_d  = ADDR_W'(N - COLS);
          din_d   = 8'h20;
          cnt_d   = CW'(N - COLS + 1);
          state_d = SCR_CLR;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          addr_d  = cnt_q[ADDR_W-1:0] + ADDR_W'(1);
          state_d = SCR_RD;
        end
      end
      SCR_CLR, CLEAR: begin
        if (cnt_q < CW'(N)) begin
          we_d   = 1'b1;
          addr_d = cnt_q[ADDR_W-1:0];
          din_d  = 8'h20;
          cnt_d  = cnt_q + CW'(1);
        end else begin
          rdy_d   = 1'b1;
          state_d = IDLE;
          if (state_q == CLEAR) begin
            col_d = '0;
            row_d = '0;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign bus.char_ready = rdy_q;
  assign bus.text_addr  = addr_q;
  assign bus.text_write = we_q;
  assign bus.text_in    = din_q;
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;
endmodule

// File: tb/tb_text_console.sv
// Bench for text_console on a 4x3 screen: table of bytes with expected cursor and
// ready-low time, a reference screen model feeding an expected-write queue.
module tb_text_console;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int AW   = 12;
  localparam int N    = COLS * ROWS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  text_console_if #(.ADDR_W(AW)) tcif();

  text_console #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tcif.slave)
  );

  // behavioural text RAM with one-cycle read latency
  logic [7:0] mem [0:N-1];
  always @(posedge clk) begin
    if (tcif.text_write && int'(tcif.text_addr) < N) mem[tcif.text_addr] <= tcif.text_in;
    tcif.text_out <= (int'(tcif.text_addr) < N) ? mem[tcif.text_addr] : 8'h00;
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  typedef struct {
    logic [7:0] ch;
    int         col;
    int         row;
    int         lo;
    bit         scr;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [7:0] scr [0:N-1];
  int   mc = 0;
  int   mr = 0;

  function automatic void check(string nm, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  always @(negedge clk) begin
    if (rst_n && tcif.text_write) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_write: got addr %0d data %02h expected no write",
                 tcif.text_addr, tcif.text_in);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write_addr_data", int'({tcif.text_addr, tcif.text_in}), int'({w.a, w.d}));
      end
    end
  end

  function automatic void push_w(int a, logic [7:0] d);
    exp_q.push_back('{AW'(a), d});
  endfunction

  function automatic void model_scroll();
    for (int s = COLS; s < N; s++) begin
      push_w(s - COLS, scr[s]);
      scr[s - COLS] = scr[s];
    end
    for (int c = 0; c < COLS; c++) begin
      push_w(N - COLS + c, 8'h20);
      scr[N - COLS + c] = 8'h20;
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      push_w(i, 8'h20);
      scr[i] = 8'h20;
    end
    mc = 0;
    mr = 0;
  endfunction

  function automatic void model_char(logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      push_w(mr * COLS + mc, ch);
      scr[mr * COLS + mc] = ch;
      mc++;
      if (mc == COLS) begin
        mc = 0;
        if (mr == ROWS - 1) model_scroll();
        else mr++;
      end
    end else if (ch == 8'h0A) begin
      mc = 0;
      if (mr == ROWS - 1) model_scroll();
      else mr++;
    end else if (ch == 8'h0D) begin
      mc = 0;
    end else if (ch == 8'h08) begin
      if (mc > 0) begin
        mc--;
        push_w(mr * COLS + mc, 8'h20);
        scr[mr * COLS + mc] = 8'h20;
      end
    end else if (ch == 8'h0C) begin
      model_clear();
    end
  endfunction

  task automatic count_low(output int lo);
    lo = 0;
    forever begin
      @(negedge clk);
      if (tcif.char_ready === 1'b1) break;
      lo++;
      if (lo > 300) break;
    end
  endtask

  task automatic check_screen(string tag);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_ram%0d", tag, i), int'(mem[i]), int'(scr[i]));
  endtask

  task automatic send(input vec_t v);
    int lo;
    model_char(v.ch);
    tcif.char_data  = v.ch;
    tcif.char_valid = 1'b1;
    @(posedge clk);
    #1 tcif.char_valid = 1'b0;
    count_low(lo);
    $display("send %02h: cursor=(%0d,%0d) ready_low=%0d", v.ch,
             tcif.cursor_col, tcif.cursor_row, lo);
    check($sformatf("ready_low_%02h", v.ch), lo, v.lo);
    check($sformatf("cursor_col_%02h", v.ch), int'(tcif.cursor_col), v.col);
    check($sformatf("cursor_row_%02h", v.ch), int'(tcif.cursor_row), v.row);
    check("pending_writes", exp_q.size(), 0);
    if (v.scr) check_screen("screen");
  endtask

  initial begin
    int lo;
    tcif.char_valid = 1'b0;
    tcif.char_data  = 8'h00;
    //                ch     col row lo scr
    vecs.push_back('{8'h41, 1, 0, 1,  0});
    vecs.push_back('{8'h42, 2, 0, 1,  0});
    vecs.push_back('{8'h0D, 0, 0, 1,  0});
    vecs.push_back('{8'h58, 1, 0, 1,  0});
    vecs.push_back('{8'h58, 2, 0, 1,  0});
    vecs.push_back('{8'h58, 3, 0, 1,  0});
    vecs.push_back('{8'h58, 0, 1, 1,  0});
    vecs.push_back('{8'h61, 1, 1, 1,  0});
    vecs.push_back('{8'h62, 2, 1, 1,  0});
    vecs.push_back('{8'h0A, 0, 2, 1,  0});
    vecs.push_back('{8'h08, 0, 2, 1,  0});
    vecs.push_back('{8'h01, 0, 2, 1,  0});
    vecs.push_back('{8'h70, 1, 2, 1,  0});
    vecs.push_back('{8'h71, 2, 2, 1,  0});
    vecs.push_back('{8'h72, 3, 2, 1,  0});
    vecs.push_back('{8'h0A, 0, 2, 28, 1});
    vecs.push_back('{8'h6B, 1, 2, 1,  0});
    vecs.push_back('{8'h08, 0, 2, 1,  0});
    vecs.push_back('{8'h6D, 1, 2, 1,  0});
    vecs.push_back('{8'h6E, 2, 2, 1,  0});
    vecs.push_back('{8'h6F, 3, 2, 1,  0});
    vecs.push_back('{8'h7A, 0, 2, 29, 1});
    vecs.push_back('{8'h63, 1, 2, 1,  0});
    vecs.push_back('{8'h0C, 0, 0, 13, 1});
    vecs.push_back('{8'h0A, 0, 1, 1,  0});
    vecs.push_back('{8'h0A, 0, 2, 1,  0});

    repeat (3) @(negedge clk);
    check("rst_text_write", int'(tcif.text_write), 0);
    check("rst_char_ready", int'(tcif.char_ready), 0);
    check("rst_text_addr",  int'(tcif.text_addr), 0);
    check("rst_text_in",    int'(tcif.text_in), 0);
    check("rst_cursor_col", int'(tcif.cursor_col), 0);
    check("rst_cursor_row", int'(tcif.cursor_row), 0);

    model_clear();
    rst_n = 1'b1;
    count_low(lo);
    $display("reset release: clear ready_low=%0d", lo);
    check("init_clear_len", lo, N);
    check("init_cursor_col", int'(tcif.cursor_col), 0);
    check("init_cursor_row", int'(tcif.cursor_row), 0);
    check("init_pending", exp_q.size(), 0);
    check_screen("init");

    for (int i = 0; i < vecs.size(); i++) send(vecs[i]);

    // LF on the last row, then reset ten cycles into the scroll
    model_char(8'h0A);
    tcif.char_data  = 8'h0A;
    tcif.char_valid = 1'b1;
    @(posedge clk);
    #1 tcif.char_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-scroll: text_write=%0d char_ready=%0d", tcif.text_write, tcif.char_ready);
    check("abort_text_write", int'(tcif.text_write), 0);
    check("abort_char_ready", int'(tcif.char_ready), 0);
    exp_q.delete();
    tcif.char_data  = 8'h51;
    tcif.char_valid = 1'b1;
    repeat (3) @(negedge clk);
    model_clear();
    rst_n = 1'b1;
    count_low(lo);
    tcif.char_valid = 1'b0;
    $display("reset release after abort: clear ready_low=%0d", lo);
    check("abort_clear_len", lo, N);
    check("abort_cursor_col", int'(tcif.cursor_col), 0);
    check("abort_cursor_row", int'(tcif.cursor_row), 0);
    repeat (4) @(negedge clk);
    check("abort_pending", exp_q.size(), 0);
    check_screen("abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
